histogram_accumulator: RTL and testbench

- Downstream of plot_distributer. Consumes its 7-bit bin address and one-cycle increment strobe.
- Maintains a 128-bin coincidence histogram in on-chip RAM using a pipelined read-modify-write.
- Provides an independent read port for host/UART readout, a full-memory clear sweep and saturation flags.

---
 rtl/histogram_accumulator.sv | 161 ++++++++++++++++
 tb/tb_histogram_accumulator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_accumulator.sv
// histogram_accumulator: 2**ADDR_W-bin coincidence histogram built on a pipelined
// read-modify-write. Each increment strobe is followed ADDR_DELAY cycles later by
// its bin address. Reset and clear both zero the RAM with a full sweep. An
// independent read port serves the host, and the block reports a saturation flag
// and a count of increments dropped while a sweep was running.
module histogram_accumulator #(
  parameter int ADDR_W     = 7,
  parameter int COUNT_W    = 16,
  parameter int TOTAL_W    = 32,
  parameter int ADDR_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic [ADDR_W-1:0]  inc_addr,
  input  logic               clear,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [COUNT_W-1:0] rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic [TOTAL_W-1:0] total_count,
  output logic               sat_flag,
  output logic [7:0]         drop_count
);

  localparam int NBINS = 2 ** ADDR_W;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W-1:0]  PTR_MAX = '1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [COUNT_W-1:0] mem_q [NBINS];

  logic [ADDR_DELAY-1:0] inc_dly_q;
  logic               s0_vld, run, drop, s2_commit;
  logic               vld1_q, vld1_d, vld2_q, vld2_d;
  logic [ADDR_W-1:0]  a1_q, a2_q;
  logic [COUNT_W-1:0] old2_q, new2;

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COUNT_W-1:0] wr_data;

  logic [TOTAL_W-1:0] total_q, total_d;
  logic               sat_q, sat_d;
  logic [7:0]         drop_q, drop_d;
  logic [COUNT_W-1:0] rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  // S0 is the cycle in which the delayed strobe lines up with a valid inc_addr.
  assign s0_vld    = inc_dly_q[ADDR_DELAY-1];
  assign run       = (state_q == ST_RUN);
  assign drop      = s0_vld && !run;
  assign s2_commit = vld2_q && run && !clear;
  // A bin never wraps: once all-ones it keeps rewriting all-ones.
  assign new2      = (old2_q == CNT_MAX) ? old2_q : old2_q + COUNT_W'(1);

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign busy        = !run;
  assign total_count = total_q;
  assign sat_flag    = sat_q;
  assign drop_count  = drop_q;

  // Sweep FSM next state and the single RAM write port mux.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_addr = a2_q;
    wr_data = new2;
    case (state_q)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        wr_data = '0;
        if (clear) begin
          ptr_d = '0;
        end else if (ptr_q == PTR_MAX) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        wr_en = s2_commit;
        if (clear) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
    endcase
  end

  // Pipeline valids, event counters, flags and readout next state.
  always_comb begin
    vld1_d     = s0_vld && run && !clear;
    vld2_d     = vld1_q && run && !clear;
    total_d    = total_q;
    sat_d      = sat_q;
    drop_d     = drop_q;
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (clear) begin
      total_d = '0;
      sat_d   = 1'b0;
      drop_d  = '0;
    end else begin
      if (s2_commit) begin
        total_d = total_q + TOTAL_W'(1);
        if (new2 == CNT_MAX) sat_d = 1'b1;
      end
      if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end
    if (rd_en) begin
      if (!run)                             rd_data_d = '0;
      else if (wr_en && wr_addr == rd_addr) rd_data_d = wr_data;
      else                                  rd_data_d = mem_q[rd_addr];
    end
  end

  // Control state with asynchronous reset; reset restarts the sweep from bin 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      inc_dly_q  <= '0;
      vld1_q     <= 1'b0;
      vld2_q     <= 1'b0;
      total_q    <= '0;
      sat_q      <= 1'b0;
      drop_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      inc_dly_q  <= (inc_dly_q << 1) | ADDR_DELAY'(inc);
      vld1_q     <= vld1_d;
      vld2_q     <= vld2_d;
      total_q    <= total_d;
      sat_q      <= sat_d;
      drop_q     <= drop_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Datapath: S0->S1 address capture, S1 RAM read with S2 forwarding, RAM write.
  always_ff @(posedge clk) begin
    a1_q   <= inc_addr;
    a2_q   <= a1_q;
    old2_q <= (wr_en && wr_addr == a1_q) ? wr_data : mem_q[a1_q];
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_histogram_accumulator.sv
// Bench for histogram_accumulator: randomized and directed increment traffic
// against a bin-array reference model, readouts checked through a scoreboard.
module tb_histogram_accumulator;

  localparam int AW = 7;
  localparam int CW = 16;
  localparam int TW = 32;
  localparam int NB = 128;

  logic          clk = 1'b0;
  logic          rst, inc, clear, rd_en;
  logic [AW-1:0] inc_addr, rd_addr;
  logic [CW-1:0] rd_data;
  logic          rd_valid, busy, sat_flag;
  logic [TW-1:0] total_count;
  logic [7:0]    drop_count;

  histogram_accumulator #(.ADDR_W(AW), .COUNT_W(CW), .TOTAL_W(TW), .ADDR_DELAY(1)) dut (
    .clk(clk), .rst(rst), .inc(inc), .inc_addr(inc_addr), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .total_count(total_count), .sat_flag(sat_flag), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain bin array and counters.
  int unsigned     m_bin [NB];
  longint unsigned m_total;
  bit              m_sat;
  int              m_drop;

  typedef struct { logic [CW-1:0] data; int cyc; } rd_exp_t;
  rd_exp_t sbq[$];
  rd_exp_t e;

  // Monitor: every rd_valid must match the oldest outstanding request, one cycle later.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: got rd_valid with data %0h, required no response", rd_data);
      end else begin
        e = sbq.pop_front();
        if (rd_data !== e.data || cyc != e.cyc + 1) begin
          fails++;
          $display("FAIL rd_data: got %0h at cycle %0d, required %0h at cycle %0d",
                   rd_data, cyc, e.data, e.cyc + 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_bin[i] = 0;
    m_total = 0;
    m_sat   = 1'b0;
    m_drop  = 0;
  endtask

  task automatic model_inc(input int a);
    if (m_bin[a] != 32'hFFFF) m_bin[a] = m_bin[a] + 1;
    if (m_bin[a] == 32'hFFFF) m_sat = 1'b1;
    m_total = m_total + 1;
  endtask

  task automatic rd_issue(input int b, input int unsigned exp);
    rd_en   = 1'b1;
    rd_addr = AW'(b);
    sbq.push_back('{data: CW'(exp), cyc: cyc});
    step();
  endtask

  task automatic rd_all();
    for (int b = 0; b < NB; b++) rd_issue(b, m_bin[b]);
    rd_en = 1'b0;
    step();
    step();
  endtask

  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    chk(name, n, 128);
  endtask

  // Strobes inc every 'gap' cycles and presents each address one cycle after its strobe.
  task automatic burst(input int addrs[$], input int gap);
    int n;
    int last;
    n    = addrs.size();
    last = (n - 1) * gap + 1;
    foreach (addrs[i]) model_inc(addrs[i]);
    for (int k = 0; k <= last; k++) begin
      inc = (k % gap == 0) && (k / gap < n);
      if (k >= 1 && (k - 1) % gap == 0 && (k - 1) / gap < n) inc_addr = AW'(addrs[(k - 1) / gap]);
      else inc_addr = AW'($urandom);
      step();
    end
    inc = 1'b0;
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_total"}, total_count, m_total & 64'hFFFF_FFFF);
    chk({tag, "_sat"}, sat_flag, m_sat);
    chk({tag, "_drop"}, drop_count, m_drop);
  endtask

  int q[$];
  int len, g, oldv;

  initial begin
    rst = 1'b1; inc = 1'b0; clear = 1'b0; rd_en = 1'b0;
    inc_addr = '0; rd_addr = '0;
    model_reset();
    step(); step();
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 1);
    chk_counters("rst");
    rst = 1'b0;
    wait_sweep("sweep_after_reset");
    rd_all();
    chk_counters("idle");

    // Five spaced increments to bin 64.
    q.delete();
    for (int i = 0; i < 5; i++) q.push_back(64);
    burst(q, 3);
    rd_all();
    chk_counters("bin64");

    // Back-to-back same bin, then alternating neighbours.
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(40);
    burst(q, 1);
    rd_issue(40, m_bin[40]);
    rd_en = 1'b0;
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(40 + (i % 2));
    burst(q, 1);
    rd_issue(40, m_bin[40]);
    rd_issue(41, m_bin[41]);
    rd_en = 1'b0;
    step();
    chk_counters("b2b");

    // Readout around the write cycle of one increment (write lands 3 cycles after the strobe).
    oldv = m_bin[20];
    inc = 1'b1; step();
    inc = 1'b0; inc_addr = AW'(20);
    rd_issue(20, oldv);
    inc_addr = AW'($urandom);
    rd_issue(20, oldv);
    rd_issue(20, oldv + 1);
    rd_issue(20, oldv + 1);
    rd_en = 1'b0;
    model_inc(20);
    step(); step();

    // Randomized bursts, biased toward a few bins to provoke hazards.
    for (int r = 0; r < 20; r++) begin
      q.delete();
      len = $urandom_range(1, 15);
      g   = $urandom_range(1, 3);
      for (int i = 0; i < len; i++)
        q.push_back($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NB - 1));
      burst(q, g);
    end
    rd_all();
    chk_counters("random");

    // Saturation of bin 10.
    q.delete();
    for (int i = 0; i < 65534; i++) q.push_back(10);
    burst(q, 1);
    rd_issue(10, m_bin[10]);
    rd_en = 1'b0;
    step();
    chk_counters("pre_sat");
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(10);
    burst(q, 3);
    rd_issue(10, 32'hFFFF);
    rd_en = 1'b0;
    step();
    chk_counters("sat");

    // Asynchronous reset with increments in flight.
    inc = 1'b1; step();
    inc_addr = AW'(7); step();
    inc = 1'b0;
    rd_issue(10, m_bin[10]);
    rd_en = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_pipe_rd_valid", rd_valid, 0);
    chk("arst_pipe_rd_data", rd_data, 0);
    chk("arst_pipe_busy", busy, 1);
    chk_counters("arst_pipe");
    step(); step();
    rst = 1'b0;
    wait_sweep("sweep_after_pipe_reset");
    rd_all();
    chk_counters("after_pipe_reset");

    // Clear in RUN with increments arriving during the sweep.
    q.delete();
    q.push_back(10); q.push_back(64); q.push_back(64);
    burst(q, 2);
    clear = 1'b1; step();
    clear = 1'b0;
    model_reset();
    begin
      int n;
      n = 0;
      while (busy && n < 400) begin
        inc      = (n == 10 || n == 20 || n == 30 || n == 40);
        inc_addr = AW'($urandom);
        if (n == 60) begin
          rd_en   = 1'b1;
          rd_addr = AW'(64);
          sbq.push_back('{data: '0, cyc: cyc});
        end else begin
          rd_en = 1'b0;
        end
        step();
        n++;
      end
      chk("sweep_after_clear", n, 128);
    end
    inc = 1'b0; rd_en = 1'b0;
    m_drop = 4;
    step();
    chk_counters("clear");
    rd_all();

    // Asynchronous reset in the middle of a sweep, then a full-length fresh sweep.
    clear = 1'b1; step();
    clear = 1'b0;
    model_reset();
    for (int n = 0; n < 50; n++) begin
      inc      = (n == 5 || n == 15);
      inc_addr = AW'($urandom);
      if (n == 30) begin
        rd_en   = 1'b1;
        rd_addr = AW'(10);
        sbq.push_back('{data: '0, cyc: cyc});
      end else begin
        rd_en = 1'b0;
      end
      step();
    end
    inc = 1'b0;
    rd_issue(64, 0);
    rd_en = 1'b0;
    chk("sweep_drops", drop_count, 2);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_sweep_rd_valid", rd_valid, 0);
    chk("arst_sweep_busy", busy, 1);
    chk("arst_sweep_drop", drop_count, 0);
    step(); step();
    rst = 1'b0;
    wait_sweep("sweep_after_sweep_reset");
    rd_all();
    chk_counters("final");
    chk("scoreboard_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
